// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    localparam int unsigned MIN_DATA_BITS = 5;
    localparam int unsigned PAR_DATA_W    = 16;

    typedef enum logic [2:0] {
        ParNone  = 3'd0,
        ParEven  = 3'd1,
        ParOdd   = 3'd2,
        ParMark  = 3'd3,
        ParSpace = 3'd4
    } parity_mode_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak,
        StBrkMark
    } tx_state_t;

    // Reserved encodings 5..7 fall back to no parity.
    function automatic parity_mode_t decode_parity(input logic [2:0] raw);
        case (raw)
            3'd1:    return ParEven;
            3'd2:    return ParOdd;
            3'd3:    return ParMark;
            3'd4:    return ParSpace;
            default: return ParNone;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [PAR_DATA_W-1:0] data,
                                        input logic [3:0]            nbits,
                                        input parity_mode_t          mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < PAR_DATA_W; i++) begin
            if (i < int'(nbits)) x = x ^ data[i];
        end
        case (mode)
            ParEven:  return x;
            ParOdd:   return ~x;
            ParMark:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; flush beats push and pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame captured framing, own bit timer, CTS gating and break.
module uart_tx_cfg #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned BREAK_BITS    = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MAX_DATA_BITS-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [2:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          cts,
    input  logic                          break_req,
    input  logic                          flush,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import uart_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MAX_DATA_BITS-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (s_data),
        .pop     (fifo_pop),
        .flush   (flush),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && !fifo_full;

    tx_state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d, cap_div_q, cap_div_d;
    logic [3:0]               nbits_q, nbits_d;
    parity_mode_t             par_q, par_d;
    logic                     stop2_q, stop2_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_bit_q, par_bit_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     brk_pend_q, brk_pend_d;
    logic                     tx_q, tx_d;

    logic                  bit_end, boundary;
    logic [3:0]            cfg_nbits;
    logic [PAR_DATA_W-1:0] rd_ext;

    always_comb begin
        if (cfg_data_bits < 4'(MIN_DATA_BITS))      cfg_nbits = 4'(MIN_DATA_BITS);
        else if (cfg_data_bits > 4'(MAX_DATA_BITS)) cfg_nbits = 4'(MAX_DATA_BITS);
        else                                        cfg_nbits = cfg_data_bits;
    end

    always_comb begin
        rd_ext = '0;
        rd_ext[MAX_DATA_BITS-1:0] = fifo_rd_data;
    end

    assign bit_end = (div_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cap_div_d  = cap_div_q;
        nbits_d    = nbits_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        brk_pend_d = brk_pend_q | break_req;
        div_cnt_d  = bit_end ? cap_div_q : div_cnt_q - 1'b1;
        fifo_pop   = 1'b0;
        tx_done    = 1'b0;
        boundary   = 1'b0;

        unique case (state_q)
            StIdle: boundary = 1'b1;
            StStart: if (bit_end) begin
                state_d   = StData;
                tx_d      = shift_q[0];
                bit_cnt_d = CNT_W'(nbits_q - 4'd1);
            end
            StData: if (bit_end) begin
                if (bit_cnt_q == '0) begin
                    if (par_q != ParNone) begin
                        state_d = StParity;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d   = StStop;
                        tx_d      = 1'b1;
                        bit_cnt_d = CNT_W'(stop2_q);
                    end
                end else begin
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            StParity: if (bit_end) begin
                state_d   = StStop;
                tx_d      = 1'b1;
                bit_cnt_d = CNT_W'(stop2_q);
            end
            StStop: if (bit_end) begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else begin
                    tx_done  = 1'b1;
                    boundary = 1'b1;
                end
            end
            StBreak: if (bit_end) begin
                if (bit_cnt_q == '0) begin
                    state_d = StBrkMark;
                    tx_d    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            StBrkMark: if (bit_end) begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Break outranks queued data and ignores CTS.
        if (boundary) begin
            if (brk_pend_q || break_req) begin
                state_d    = StBreak;
                brk_pend_d = 1'b0;
                cap_div_d  = cfg_div;
                div_cnt_d  = cfg_div;
                bit_cnt_d  = CNT_W'(BREAK_BITS - 1);
                tx_d       = 1'b0;
            end else if (!fifo_empty && cts) begin
                state_d   = StStart;
                fifo_pop  = 1'b1;
                cap_div_d = cfg_div;
                div_cnt_d = cfg_div;
                nbits_d   = cfg_nbits;
                par_d     = decode_parity(cfg_parity);
                stop2_d   = cfg_stop2;
                shift_d   = fifo_rd_data;
                par_bit_d = parity_bit(rd_ext, cfg_nbits, decode_parity(cfg_parity));
                tx_d      = 1'b0;
            end else begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            cap_div_q  <= '0;
            nbits_q    <= 4'(MIN_DATA_BITS);
            par_q      <= ParNone;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
            brk_pend_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            cap_div_q  <= cap_div_d;
            nbits_q    <= nbits_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            brk_pend_q <= brk_pend_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_out  = tx_q;
    assign tx_busy = (state_q != StIdle);

endmodule
